// File: rtl/uart_i2c_cmd_parser_pkg.sv
// Shared types and helpers for the UART-to-I2C command parser.
//   parser_state_t : frame assembly FSM states
//   MODE_*         : one-hot operation codes carried in the MODE byte
//   i2c_cmd_t      : command word queued towards the I2C controller
//   mode_is_valid  : accepts exactly one of the four legal mode codes
//   frame_checksum : XOR of the four payload bytes
package uart_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_MODE = 3'd2,
        ST_DHI  = 3'd3,
        ST_DLO  = 3'd4,
        ST_CHK  = 3'd5
    } parser_state_t;

    localparam logic [7:0] MODE_RD1 = 8'h01;
    localparam logic [7:0] MODE_RD2 = 8'h02;
    localparam logic [7:0] MODE_WR1 = 8'h04;
    localparam logic [7:0] MODE_WR2 = 8'h08;

    typedef struct packed {
        logic [7:0]  address;
        logic [7:0]  mode;
        logic [15:0] data;
    } i2c_cmd_t;

    // Legal only if the low nibble is one-hot and the high nibble is zero.
    function automatic logic mode_is_valid(input logic [7:0] mode);
        logic ok;
        case (mode)
            MODE_RD1, MODE_RD2, MODE_WR1, MODE_WR2: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] frame_checksum(input logic [7:0] addr,
                                                  input logic [7:0] mode,
                                                  input logic [7:0] dhi,
                                                  input logic [7:0] dlo);
        return addr ^ mode ^ dhi ^ dlo;
    endfunction

endpackage

// File: rtl/uart_i2c_cmd_parser_if.sv
// Command handshake between the parser (master) and the I2C controller (slave).
//   cmd_valid   : command available
//   cmd_ready   : controller accepts the command this cycle
//   cmd_address : target register address
//   cmd_mode    : one-hot operation code
//   cmd_data    : write data {hi,lo}
interface uart_i2c_cmd_parser_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_address;
    logic [7:0]  cmd_mode;
    logic [15:0] cmd_data;

    modport master (
        output cmd_valid, cmd_address, cmd_mode, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_address, cmd_mode, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/uart_i2c_cmd_parser_fifo.sv
// cmd_fifo: generic show-ahead synchronous FIFO.
//   clk, reset  : clock, synchronous active-high reset
//   push, push_data : write request and data (honoured when full if a pop
//                     happens in the same cycle)
//   pop         : read request (ignored when empty)
//   pop_data    : head entry, valid while empty is low
//   full, empty : occupancy status
module cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign pop_data  = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/uart_i2c_cmd_parser.sv
// uart_i2c_cmd_parser: assembles PC instruction frames from the UART byte
// stream, validates them and queues commands for the I2C controller.
//   clk, reset         : clock, synchronous active-high reset
//   rx_byte, rx_valid  : byte stream from the UART receiver
//   result_buffer_full : downstream result buffer full, blocks issue
//   cmd_if (master)    : command valid/ready handshake to the I2C controller
//   err_checksum/err_mode/err_timeout/err_overflow : one-cycle error pulses
//   fifo_empty         : command queue empty
// Optional macro PARSER_CHECKSUM_EN: when defined, frames carry a trailing
// XOR checksum byte that is checked; otherwise frames end at DATA_LO.
module uart_i2c_cmd_parser
    import uart_i2c_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_byte,
    input  logic                         rx_valid,
    input  logic                         result_buffer_full,
    uart_i2c_cmd_parser_if.master        cmd_if,
    output logic                         err_checksum,
    output logic                         err_mode,
    output logic                         err_timeout,
    output logic                         err_overflow,
    output logic                         fifo_empty
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

`ifdef PARSER_CHECKSUM_EN
    localparam parser_state_t FINAL_ST = ST_CHK;
`else
    localparam parser_state_t FINAL_ST = ST_DLO;
`endif

    parser_state_t state_r;
    parser_state_t state_next_s;
    logic [TW-1:0] tcnt_r;
    logic          timeout_hit_s;
    logic [7:0]    addr_r;
    logic [7:0]    mode_r;
    logic [7:0]    dhi_r;
    logic [7:0]    dlo_s;
`ifdef PARSER_CHECKSUM_EN
    logic [7:0]    dlo_r;
`endif
    logic          chk_bad_s;
    logic          mode_bad_s;
    logic          ovf_s;
    logic          push_s;
    logic          pop_s;
    logic          cmd_valid_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    i2c_cmd_t      push_cmd_s;
    i2c_cmd_t      head_s;

`ifdef PARSER_CHECKSUM_EN
    assign dlo_s = dlo_r;
`else
    // Without a checksum byte the final byte is consumed straight off the bus.
    assign dlo_s = rx_byte;
`endif

    assign push_cmd_s = '{address: addr_r, mode: mode_r, data: {dhi_r, dlo_s}};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; an rx_valid on the expiry cycle takes precedence.
    always_comb begin
        state_next_s  = state_r;
        timeout_hit_s = 1'b0;
        if (state_r != ST_IDLE && !rx_valid && tcnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit_s = 1'b1;
            state_next_s  = ST_IDLE;
        end else if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_next_s = ST_ADDR;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ADDR: state_next_s = ST_MODE;
                ST_MODE: state_next_s = ST_DHI;
                ST_DHI:  state_next_s = ST_DLO;
`ifdef PARSER_CHECKSUM_EN
                ST_DLO:  state_next_s = ST_CHK;
`else
                ST_DLO:  state_next_s = ST_IDLE;
`endif
                ST_CHK:  state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Inter-byte timeout counter, running only while a frame is open.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_r <= {TW{1'b0}};
        end else if (state_r == ST_IDLE || rx_valid || timeout_hit_s) begin
            tcnt_r <= {TW{1'b0}};
        end else begin
            tcnt_r <= tcnt_r + TW'(1);
        end
    end

    // Frame byte registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r <= 8'h00;
            mode_r <= 8'h00;
            dhi_r  <= 8'h00;
`ifdef PARSER_CHECKSUM_EN
            dlo_r  <= 8'h00;
`endif
        end else if (rx_valid) begin
            case (state_r)
                ST_ADDR: addr_r <= rx_byte;
                ST_MODE: mode_r <= rx_byte;
                ST_DHI:  dhi_r  <= rx_byte;
`ifdef PARSER_CHECKSUM_EN
                ST_DLO:  dlo_r  <= rx_byte;
`endif
                default: addr_r <= addr_r;
            endcase
        end
    end

    // Final-byte validation, priority checksum > mode > overflow. A pop in
    // the same cycle frees a slot, so a full queue only overflows without one.
    always_comb begin
        chk_bad_s  = 1'b0;
        mode_bad_s = 1'b0;
        ovf_s      = 1'b0;
        push_s     = 1'b0;
        if (rx_valid && state_r == FINAL_ST) begin
`ifdef PARSER_CHECKSUM_EN
            if (rx_byte != frame_checksum(addr_r, mode_r, dhi_r, dlo_r)) begin
                chk_bad_s = 1'b1;
            end else
`endif
            if (!mode_is_valid(mode_r)) begin
                mode_bad_s = 1'b1;
            end else if (fifo_full_s && !pop_s) begin
                ovf_s = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Registered one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_checksum <= 1'b0;
            err_mode     <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_checksum <= chk_bad_s;
            err_mode     <= mode_bad_s;
            err_timeout  <= timeout_hit_s;
            err_overflow <= ovf_s;
        end
    end

    cmd_fifo #(
        .WIDTH ($bits(i2c_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Issue is withheld (entry retained) while the result buffer is full.
    assign cmd_valid_s        = !fifo_empty_s && !result_buffer_full;
    assign pop_s              = cmd_valid_s && cmd_if.cmd_ready;
    assign cmd_if.cmd_valid   = cmd_valid_s;
    assign cmd_if.cmd_address = head_s.address;
    assign cmd_if.cmd_mode    = head_s.mode;
    assign cmd_if.cmd_data    = head_s.data;
    assign fifo_empty         = fifo_empty_s;

endmodule

// File: tb/tb_uart_i2c_cmd_parser.sv
// Self-checking bench for uart_i2c_cmd_parser: directed scenarios with
// literal expectations plus randomized traffic, all compared every cycle
// against a frame-level reference model (byte queue + command queue).
module tb_uart_i2c_cmd_parser;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         DEPTH = 4;
    localparam int         TOUT  = 16;
`ifdef PARSER_CHECKSUM_EN
    localparam int         NBYTES = 5;
`else
    localparam int         NBYTES = 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       result_buffer_full = 1'b0;
    logic       err_checksum, err_mode, err_timeout, err_overflow, fifo_empty;

    uart_i2c_cmd_parser_if cmd_if();

    uart_i2c_cmd_parser #(
        .SYNC_BYTE      (SYNC),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .rx_byte            (rx_byte),
        .rx_valid           (rx_valid),
        .result_buffer_full (result_buffer_full),
        .cmd_if             (cmd_if.master),
        .err_checksum       (err_checksum),
        .err_mode           (err_mode),
        .err_timeout        (err_timeout),
        .err_overflow       (err_overflow),
        .fifo_empty         (fifo_empty)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    bit rnd_hs  = 1'b0;

    // Reference model state.
    bit          m_in_frame = 1'b0;
    logic [7:0]  fb[$];
    int          m_idle = 0;
    logic [31:0] cq[$];
    logic        e_chk = 1'b0, e_mode = 1'b0, e_to = 1'b0, e_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs just sampled.
    task automatic model_update();
        logic        pop;
        logic        push;
        logic [31:0] entry;
        push = 1'b0;
        entry = 32'h0;
        e_chk = 1'b0; e_mode = 1'b0; e_to = 1'b0; e_ovf = 1'b0;
        if (reset) begin
            m_in_frame = 1'b0;
            fb.delete();
            m_idle = 0;
            cq.delete();
            return;
        end
        pop = (cq.size() > 0) && !result_buffer_full && cmd_if.cmd_ready;
        if (rx_valid) begin
            if (!m_in_frame) begin
                if (rx_byte == SYNC) begin
                    m_in_frame = 1'b1;
                    fb.delete();
                    m_idle = 0;
                end
            end else begin
                fb.push_back(rx_byte);
                m_idle = 0;
                if (fb.size() == NBYTES) begin
                    m_in_frame = 1'b0;
`ifdef PARSER_CHECKSUM_EN
                    if (fb[4] != (fb[0] ^ fb[1] ^ fb[2] ^ fb[3])) e_chk = 1'b1;
                    else
`endif
                    if (!(fb[1] inside {8'h01, 8'h02, 8'h04, 8'h08})) e_mode = 1'b1;
                    else if (cq.size() >= DEPTH && !pop) e_ovf = 1'b1;
                    else begin
                        push = 1'b1;
                        entry = {fb[0], fb[1], fb[2], fb[3]};
                    end
                end
            end
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle >= TOUT) begin
                e_to = 1'b1;
                m_in_frame = 1'b0;
            end
        end
        if (pop) void'(cq.pop_front());
        if (push) cq.push_back(entry);
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        if (rnd_hs) begin
            cmd_if.cmd_ready   = ($urandom_range(0, 3) != 0);
            result_buffer_full = ($urandom_range(0, 7) == 0);
        end
        rx_valid = v;
        rx_byte  = b;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] m, input logic [7:0] h,
                              input logic [7:0] l, input bit bad_chk, input int gap_max);
        logic [7:0] bytes[$];
        logic [7:0] c;
        c = a ^ m ^ h ^ l;
        bytes = '{SYNC, a, m, h, l};
`ifdef PARSER_CHECKSUM_EN
        bytes.push_back(bad_chk ? ~c : c);
`else
        if (bad_chk) c = 8'h00;
`endif
        foreach (bytes[i]) begin
            if (gap_max > 0 && i > 0) idle($urandom_range(0, gap_max));
            step(1'b1, bytes[i]);
        end
        rx_valid = 1'b0;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cmd_valid", {31'b0, cmd_if.cmd_valid}, {31'b0, (cq.size() > 0) && !result_buffer_full});
            check("fifo_empty", {31'b0, fifo_empty}, {31'b0, cq.size() == 0});
            check("err_checksum", {31'b0, err_checksum}, {31'b0, e_chk});
            check("err_mode", {31'b0, err_mode}, {31'b0, e_mode});
            check("err_timeout", {31'b0, err_timeout}, {31'b0, e_to});
            check("err_overflow", {31'b0, err_overflow}, {31'b0, e_ovf});
            if (cq.size() > 0)
                check("cmd_head", {cmd_if.cmd_address, cmd_if.cmd_mode, cmd_if.cmd_data}, cq[0]);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] md;
        int r;
        cmd_if.cmd_ready = 1'b1;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk_on = 1'b1;
        // Reset values.
        check("rst_valid", {31'b0, cmd_if.cmd_valid}, 32'd0);
        check("rst_empty", {31'b0, fifo_empty}, 32'd1);
        check("rst_fields", {cmd_if.cmd_address, cmd_if.cmd_mode, cmd_if.cmd_data}, 32'h0);

        // Basic frame, issued one cycle after the last byte.
        send_frame(8'h48, 8'h02, 8'h00, 8'h00, 1'b0, 0);
        check("a_valid", {31'b0, cmd_if.cmd_valid}, 32'd1);
        check("a_addr", {24'b0, cmd_if.cmd_address}, 32'h48);
        check("a_mode", {24'b0, cmd_if.cmd_mode}, 32'h02);
        check("a_data", {16'b0, cmd_if.cmd_data}, 32'h0000);
        idle(1);
        check("a_popped", {31'b0, fifo_empty}, 32'd1);

        // Bad mode.
        send_frame(8'h10, 8'h05, 8'h12, 8'h34, 1'b0, 0);
        check("badmode_pulse", {31'b0, err_mode}, 32'd1);
        check("badmode_empty", {31'b0, fifo_empty}, 32'd1);
`ifdef PARSER_CHECKSUM_EN
        send_frame(8'h48, 8'h02, 8'h00, 8'h00, 1'b1, 0);
        check("badchk_pulse", {31'b0, err_checksum}, 32'd1);
        check("badchk_nomode", {31'b0, err_mode}, 32'd0);
`endif
        idle(2);

        // Timeout after partial frame, then a good frame.
        step(1'b1, SYNC);
        step(1'b1, 8'h48);
        idle(TOUT - 1);
        check("to_not_yet", {31'b0, err_timeout}, 32'd0);
        idle(1);
        check("to_pulse", {31'b0, err_timeout}, 32'd1);
        idle(1);
        check("to_once", {31'b0, err_timeout}, 32'd0);
        send_frame(8'h21, 8'h04, 8'hBE, 8'hEF, 1'b0, 0);
        check("to_next_addr", {24'b0, cmd_if.cmd_address}, 32'h21);
        idle(2);

        // Overflow with stalled controller, then ordered drain.
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_frame(8'h10 + 8'(i), 8'h01 << (i % 4), 8'(i), 8'h5A, 1'b0, 0);
        check("ovf_pulse", {31'b0, err_overflow}, 32'd1);
        check("ovf_head", {24'b0, cmd_if.cmd_address}, 32'h10);
        cmd_if.cmd_ready = 1'b1;
        idle(6);
        check("ovf_drained", {31'b0, fifo_empty}, 32'd1);

        // Result buffer full holds issue.
        result_buffer_full = 1'b1;
        send_frame(8'h30, 8'h08, 8'h11, 8'h22, 1'b0, 0);
        send_frame(8'h31, 8'h01, 8'h33, 8'h44, 1'b0, 0);
        idle(4);
        check("rbf_blocked", {31'b0, cmd_if.cmd_valid}, 32'd0);
        check("rbf_kept", {31'b0, fifo_empty}, 32'd0);
        result_buffer_full = 1'b0;
        idle(3);

        // Garbage before a frame.
        step(1'b1, 8'h00); step(1'b1, 8'hFF); step(1'b1, 8'h13);
        send_frame(8'h77, 8'h02, 8'h01, 8'h02, 1'b0, 0);
        check("garbage_addr", {24'b0, cmd_if.cmd_address}, 32'h77);
        idle(2);

        // Reset mid-frame.
        step(1'b1, SYNC); step(1'b1, 8'h40); step(1'b1, 8'h02);
        reset = 1'b1;
        step(1'b0, 8'h00);
        reset = 1'b0;
        step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h41);
        idle(2);
        check("rst_mid_empty", {31'b0, fifo_empty}, 32'd1);

        // Randomized traffic.
        rnd_hs = 1'b1;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                reset = 1'b1;
                step(1'b0, 8'h00);
                reset = 1'b0;
            end else if (r < 15) begin
                step(1'b1, 8'($urandom));
            end else if (r < 25) begin
                idle($urandom_range(1, 20));
            end else begin
                md = (r < 35) ? 8'($urandom) : (8'h01 << $urandom_range(0, 3));
                send_frame(8'($urandom), md, 8'($urandom), 8'($urandom),
                           (r % 10) == 0, (r < 32) ? 18 : 1);
            end
        end
        rnd_hs = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        result_buffer_full = 1'b0;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_i2c_cmd_parser.md
Name: uart_i2c_cmd_parser

Overview:
- PC-to-sensor direction of the thermometer link.
- Assembles PC instruction frames byte-by-byte from the UART receiver and validates sync, mode and checksum.
- Queues valid commands in a small FIFO and issues them to the I2C controller over a valid/ready handshake.
- Holds issue while the I2C-to-UART result buffer reports full, so no result is lost downstream.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- FIFO_DEPTH, 4, command queue entries (power of 2, >=2).
- TIMEOUT_CYCLES, 100000, max clk cycles between bytes inside a frame.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rx_byte  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- result_buffer_full  in  1  I2C result buffer full; blocks issue
- cmd_ready  in  1  I2C controller accepts command
- cmd_valid  out  1  command available
- cmd_address  out  8  target register address
- cmd_mode  out  8  one-hot op in [3:0]: 0001 rd1, 0010 rd2, 0100 wr1, 1000 wr2; [7:4] zero
- cmd_data  out  16  write data {hi,lo}; passed through unchanged for reads
- err_checksum  out  1  one-cycle pulse
- err_mode  out  1  one-cycle pulse
- err_timeout  out  1  one-cycle pulse
- err_overflow  out  1  one-cycle pulse
- fifo_empty  out  1  status

Behaviour:
- Frame order: SYNC, ADDR, MODE, DATA_HI, DATA_LO, CHK.
- CHK = ADDR^MODE^DATA_HI^DATA_LO.
- FSM states: IDLE, ADDR, MODE, DHI, DLO, CHK. Each state advances only on rx_valid.
- IDLE: byte == SYNC_BYTE -> ADDR. Any other byte is discarded silently.
- Each state latches its byte into a frame register, then moves to the next state. CHK returns to IDLE.
- Validation is combinational on the final byte.
  - CHK mismatch -> err_checksum.
  - Else mode[3:0] not one-hot, or mode[7:4] != 0 -> err_mode.
  - Else FIFO full -> err_overflow.
  - Else FIFO write.
- Only one error pulse per frame, priority checksum > mode > overflow. The pulse occurs the cycle after the final byte's sampling edge.
- Timeout:
  - Counter clears on every rx_valid and counts only in non-IDLE states.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, partial frame discarded, err_timeout pulsed once.
  - If rx_valid arrives on the expiry cycle, the byte wins and there is no timeout.
- FIFO behaviour:
  - Show-ahead: outputs are the head entry.
  - cmd_valid = !fifo_empty && !result_buffer_full.
  - Pop on cmd_valid && cmd_ready.
  - Push and pop in the same cycle are both honoured, including when full. A pop in the final-byte cycle frees space, so no overflow.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy uses a counter of width clog2(FIFO_DEPTH)+1.
- Latency: final byte sampled at edge N -> cmd_valid high after edge N (FIFO was empty, not blocked).
- Handshake rules:
  - cmd_* stable while cmd_valid && !cmd_ready.
  - If result_buffer_full rises, cmd_valid drops the same cycle and the entry is retained.
- Reset values:
  - FSM = IDLE; FIFO emptied; timeout counter = 0.
  - cmd_valid = 0; cmd_address, cmd_mode, cmd_data = 0; all err_* = 0; fifo_empty = 1.
  - Reset mid-frame discards the partial frame, with no error pulse.

Optional Feature:
- PARSER_CHECKSUM_EN
- Defined: CHK byte is required and checked as above.
- Undefined: frame is 5 bytes, with no CHK state. Validation is done on DATA_LO, err_checksum is tied 0, and the mode and overflow checks are unchanged.

Decomposition:
- Package uart_i2c_pkg holds:
  - parser_state_t enum;
  - MODE_RD1/RD2/WR1/WR2 one-hot constants;
  - i2c_cmd_t struct {address, mode, data}.
- Sub-module cmd_fifo: parameterised on i2c_cmd_t width and FIFO_DEPTH, with push/pop/full/empty. It is reusable elsewhere.

Test Plan:
- Frame A5,48,02,00,00,4A with cmd_ready=1 -> cmd_valid 1 cycle after the last byte; address 8'h48, mode 8'h02, data 16'h0000; popped that cycle.
- Frame A5,10,05,12,34,33 (bad mode) -> err_mode pulse, FIFO stays empty. Bad CHK 00 on a valid frame -> err_checksum only.
- Send A5,48 then idle TIMEOUT_CYCLES (param set to 16) -> err_timeout once; the next full frame parses correctly.
- cmd_ready=0, send 5 valid frames with FIFO_DEPTH=4 -> 4 queued, 5th gives err_overflow; then cmd_ready=1 -> 4 pops in order with matching data.
- result_buffer_full=1 with 2 queued -> cmd_valid=0, nothing lost; release -> both issued in order.
- Garbage bytes 00,FF,13 before A5 frame -> ignored, frame accepted. Reset asserted after the MODE byte -> no command, no error pulse.
